// File: rtl/c432_response_analyzer.sv
// Response analyzer for the c432 trojan-detection flow: compacts golden and
// suspect output streams into MISR signatures and accumulates mismatch statistics.
module c432_response_analyzer #(
  parameter int                NOUT      = 7,
  parameter int                CNT_W     = 16,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
  parameter logic [MISR_W-1:0] MISR_SEED = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     num_patterns,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NOUT-1:0]      golden,
  input  logic [NOUT-1:0]      suspect,
  output logic                 busy,
  output logic                 done,
  output logic [MISR_W-1:0]    misr_g,
  output logic [MISR_W-1:0]    misr_s,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CNT_W+2:0]     hamming_sum,
  output logic [NOUT-1:0]      bit_fail_mask,
  output logic [CNT_W-1:0]     first_fail_idx,
  output logic                 first_fail_vld,
  output logic                 trojan_flag
);

  localparam int HS_W = CNT_W + 3;
  localparam int PC_W = $clog2(NOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [MISR_W-1:0] misr_g_q, misr_g_d;
  logic [MISR_W-1:0] misr_s_q, misr_s_d;
  logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic [HS_W-1:0]   hamming_sum_q, hamming_sum_d;
  logic [NOUT-1:0]   bit_fail_mask_q, bit_fail_mask_d;
  logic [CNT_W-1:0]  first_fail_idx_q, first_fail_idx_d;
  logic              first_fail_vld_q, first_fail_vld_d;

  logic [NOUT-1:0]   diff;
  logic [PC_W-1:0]   popcnt;
  logic              xfer;

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [NOUT-1:0]   v);
    misr_step = {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(v);
  endfunction

  always_comb begin
    diff   = golden ^ suspect;
    popcnt = '0;
    for (int unsigned i = 0; i < NOUT; i++) begin
      popcnt = popcnt + PC_W'(diff[i]);
    end
  end

  assign xfer = (state_q == S_RUN) && in_valid;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    num_d            = num_q;
    misr_g_d         = misr_g_q;
    misr_s_d         = misr_s_q;
    mismatch_cnt_d   = mismatch_cnt_q;
    hamming_sum_d    = hamming_sum_q;
    bit_fail_mask_d  = bit_fail_mask_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_vld_d = first_fail_vld_q;

    if ((state_q == S_RUN || state_q == S_DONE) && abort) begin
      // abort wins over start and over a same-cycle transfer; results are kept
      state_d = S_IDLE;
    end else if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      num_d            = num_patterns;
      idx_d            = '0;
      misr_g_d         = MISR_SEED;
      misr_s_d         = MISR_SEED;
      mismatch_cnt_d   = '0;
      hamming_sum_d    = '0;
      bit_fail_mask_d  = '0;
      first_fail_idx_d = '0;
      first_fail_vld_d = 1'b0;
      state_d          = (num_patterns == '0) ? S_DONE : S_RUN;
    end else if (xfer) begin
      misr_g_d        = misr_step(misr_g_q, golden);
      misr_s_d        = misr_step(misr_s_q, suspect);
      hamming_sum_d   = hamming_sum_q + HS_W'(popcnt);
      bit_fail_mask_d = bit_fail_mask_q | diff;
      if (diff != '0) begin
        if (mismatch_cnt_q != '1) begin
          mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
        end
        if (!first_fail_vld_q) begin
          first_fail_idx_d = idx_q;
          first_fail_vld_d = 1'b1;
        end
      end
      idx_d = idx_q + CNT_W'(1);
      if (idx_q == num_q - CNT_W'(1)) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      num_q            <= '0;
      misr_g_q         <= MISR_SEED;
      misr_s_q         <= MISR_SEED;
      mismatch_cnt_q   <= '0;
      hamming_sum_q    <= '0;
      bit_fail_mask_q  <= '0;
      first_fail_idx_q <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      num_q            <= num_d;
      misr_g_q         <= misr_g_d;
      misr_s_q         <= misr_s_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
      hamming_sum_q    <= hamming_sum_d;
      bit_fail_mask_q  <= bit_fail_mask_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_vld_q <= first_fail_vld_d;
    end
  end

  assign in_ready       = (state_q == S_RUN);
  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign misr_g         = misr_g_q;
  assign misr_s         = misr_s_q;
  assign mismatch_cnt   = mismatch_cnt_q;
  assign hamming_sum    = hamming_sum_q;
  assign bit_fail_mask  = bit_fail_mask_q;
  assign first_fail_idx = first_fail_idx_q;
  assign first_fail_vld = first_fail_vld_q;
  assign trojan_flag    = done & ((mismatch_cnt_q != '0) | (misr_g_q != misr_s_q));

endmodule

// File: tb/tb_c432_response_analyzer.sv
// Scoreboard bench for c432_response_analyzer: runs are modelled from the list of
// accepted vectors and checked by a monitor whenever done rises.
module tb_c432_response_analyzer;

  logic        clk, rst, start, abort, in_valid;
  logic [15:0] num_patterns;
  logic [6:0]  golden, suspect;
  logic        in_ready, busy, done, first_fail_vld, trojan_flag;
  logic [15:0] misr_g, misr_s, mismatch_cnt, first_fail_idx;
  logic [18:0] hamming_sum;
  logic [6:0]  bit_fail_mask;

  c432_response_analyzer #(
    .NOUT(7), .CNT_W(16), .MISR_W(16), .MISR_POLY(16'h1021), .MISR_SEED(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_patterns(num_patterns),
    .in_valid(in_valid), .in_ready(in_ready), .golden(golden), .suspect(suspect),
    .busy(busy), .done(done), .misr_g(misr_g), .misr_s(misr_s),
    .mismatch_cnt(mismatch_cnt), .hamming_sum(hamming_sum), .bit_fail_mask(bit_fail_mask),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld), .trojan_flag(trojan_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mg, ms, mc, ffi;
    logic [18:0] hs;
    logic [6:0]  mask;
    logic        ffv;
  } res_t;

  int errors = 0;
  int checks = 0;
  res_t exp_q[$];
  logic [6:0] gq[$], sq[$];
  logic [6:0] dg[$], ds[$];

  // signature step written as integer arithmetic over GF(2) polynomial division
  function automatic int unsigned misr_ref(input int unsigned m, input int unsigned v);
    int unsigned x;
    x = m * 2;
    if (x >= 65536) x = (x - 65536) ^ 32'h1021;
    return x ^ v;
  endfunction

  function automatic res_t model(input logic [6:0] g[$], input logic [6:0] s[$]);
    res_t r;
    int unsigned mg, ms, mc, hs;
    logic [6:0] d;
    mg = 0; ms = 0; mc = 0; hs = 0;
    r.mask = '0; r.ffi = '0; r.ffv = 1'b0;
    foreach (g[i]) begin
      d = g[i] ^ s[i];
      if (d != 0) begin
        if (mc < 65535) mc++;
        if (!r.ffv) begin r.ffi = 16'(i); r.ffv = 1'b1; end
      end
      hs += $countones(d);
      r.mask |= d;
      mg = misr_ref(mg, g[i]);
      ms = misr_ref(ms, s[i]);
    end
    r.mg = 16'(mg); r.ms = 16'(ms); r.mc = 16'(mc); r.hs = 19'(hs);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_results(input string tag, input res_t e, input bit exp_done);
    check({tag, ".misr_g"}, 32'(misr_g), 32'(e.mg));
    check({tag, ".misr_s"}, 32'(misr_s), 32'(e.ms));
    check({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(e.mc));
    check({tag, ".hamming_sum"}, 32'(hamming_sum), 32'(e.hs));
    check({tag, ".bit_fail_mask"}, 32'(bit_fail_mask), 32'(e.mask));
    check({tag, ".first_fail_idx"}, 32'(first_fail_idx), 32'(e.ffi));
    check({tag, ".first_fail_vld"}, 32'(first_fail_vld), 32'(e.ffv));
    check({tag, ".trojan_flag"}, 32'(trojan_flag),
          32'(exp_done && (e.mc != 0 || e.mg != e.ms)));
  endtask

  // monitor: pop an expectation each time done rises
  initial begin
    logic done_d;
    res_t e;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_d) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 32'(done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check_results("sb", e, 1'b1);
        end
      end
      done_d = done;
    end
  end

  task automatic do_run(input int n, input int abort_at, input logic [31:0] vpat, input bit use_vpat);
    int k, c;
    bit aborted, v;
    logic [6:0] g, s;
    gq.delete(); sq.delete();
    @(posedge clk); #1;
    start = 1'b1; num_patterns = 16'(n);
    in_valid = 1'($urandom % 2); golden = 7'($urandom); suspect = 7'($urandom);
    if (n == 0) exp_q.push_back(model(gq, sq));
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    k = 0; c = 0; aborted = 1'b0;
    while (n > 0 && k < n && !aborted) begin
      if (c > 20 * n + 20) begin
        check("run_cycle_budget", 32'(c), 32'(20 * n + 20));
        break;
      end
      v = use_vpat ? (c < 32 ? vpat[c] : 1'b1) : ($urandom % 4 != 0);
      g = (k < dg.size()) ? dg[k] : 7'($urandom);
      if (k < ds.size()) s = ds[k];
      else s = ($urandom % 3 == 0) ? (g ^ 7'($urandom)) : g;
      in_valid = v; golden = g; suspect = s;
      abort = v && (k == abort_at);
      if (v && !abort) begin
        gq.push_back(g); sq.push_back(s); k++;
        if (k == n) exp_q.push_back(model(gq, sq));
      end
      @(negedge clk);
      check("run.in_ready", 32'(in_ready), 32'(1));
      check("run.busy", 32'(busy), 32'(1));
      @(posedge clk); #1;
      if (abort) aborted = 1'b1;
      c++;
    end
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("end.in_ready", 32'(in_ready), 32'(0));
    check("end.busy", 32'(busy), 32'(0));
    check("end.done", 32'(done), 32'(!aborted));
    if (aborted) check_results("abort", model(gq, sq), 1'b0);
    // stray vectors outside RUN must leave everything unchanged
    repeat (2) begin
      @(posedge clk); #1;
      in_valid = 1'b1; golden = 7'($urandom); suspect = 7'($urandom);
      @(negedge clk);
      check("held.in_ready", 32'(in_ready), 32'(0));
      check_results("held", model(gq, sq), !aborted);
    end
    in_valid = 1'b0;
    dg.delete(); ds.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t zero;
    gq.delete(); sq.delete();
    zero = model(gq, sq);
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    num_patterns = '0; golden = '0; suspect = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.busy", 32'(busy), 32'(0));
    check("reset.done", 32'(done), 32'(0));
    check("reset.in_ready", 32'(in_ready), 32'(0));
    check_results("reset", zero, 1'b0);

    // reset in the middle of a run after 3 transfers
    @(posedge clk); #1 start = 1'b1; num_patterns = 16'd5;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; golden = 7'h7F; suspect = 7'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset.mismatch_cnt", 32'(mismatch_cnt), 32'(3));
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset.busy", 32'(busy), 32'(0));
    check("midreset.in_ready", 32'(in_ready), 32'(0));
    check_results("midreset", zero, 1'b0);

    // single matching pattern
    dg = '{7'h55}; ds = '{7'h55};
    do_run(1, -1, 0, 1'b0);
    check("p1.misr_g", 32'(misr_g), 32'h0055);
    check("p1.misr_s", 32'(misr_s), 32'h0055);
    check("p1.trojan_flag", 32'(trojan_flag), 32'(0));

    // four patterns with two failures
    dg = '{7'h00, 7'h7F, 7'h10, 7'h22}; ds = '{7'h00, 7'h7E, 7'h13, 7'h22};
    do_run(4, -1, 0, 1'b0);
    check("p4.mismatch_cnt", 32'(mismatch_cnt), 32'd2);
    check("p4.hamming_sum", 32'(hamming_sum), 32'd3);
    check("p4.bit_fail_mask", 32'(bit_fail_mask), 32'h03);
    check("p4.first_fail_idx", 32'(first_fail_idx), 32'd1);
    check("p4.first_fail_vld", 32'(first_fail_vld), 32'd1);
    check("p4.trojan_flag", 32'(trojan_flag), 32'd1);

    // in_valid pattern 1,0,0,1,1 for three patterns
    do_run(3, -1, 32'b11001, 1'b1);

    // abort after 2 of 5 transfers, then an empty run from IDLE
    do_run(5, 2, 0, 1'b0);
    do_run(0, -1, 0, 1'b0);
    check_results("empty", zero, 1'b1);

    for (int r = 0; r < 20; r++) begin
      int n;
      n = 1 + int'($urandom % 12);
      do_run(n, ($urandom % 4 == 0) ? int'($urandom % n) : -1, 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
